// File: rtl/sp_ram_pkg.sv
// Shared widths for the single-port RAM access controller slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sp_ram_pkg;

  // Must match the addr_width/data_width of the attached single_port_ram.
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM: en=1 writes data to addr, en=0 latches addr for a read.
// Latency: q shows mem[latched addr] the cycle after the address is latched.
// Backpressure: none; accepts one operation every cycle.
module single_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 6,
  parameter int depth      = 64
) (
  input  logic                  clk,
  input  logic [data_width-1:0] data,
  input  logic [addr_width-1:0] addr,
  input  logic                  en,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] addr_reg;

  // Write on en, otherwise register the read address; contents have no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= data;
    end else begin
      addr_reg <= addr;
    end
  end

  assign q = mem[addr_reg];

endmodule

// File: rtl/sp_ram_rsp_fifo.sv
// Small response FIFO holding read data until the consumer takes it.
// Latency: pushed data visible on pop_data the cycle after the push.
// Backpressure: full/empty/count exported; push with pop is legal at any occupancy.
module sp_ram_rsp_fifo
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; a pop at full frees the slot the push reuses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  assign pop_data = store[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/sp_ram_ctrl.sv
// Arbitrates write and read request streams onto one RAM port and buffers read data.
// Latency: rd handshake in cycle N gives rsp_valid with that data in cycle N+2.
// Backpressure: rd_ready withheld when buffer plus in-flight read would exceed 2 entries.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int RSP_DEPTH = 2;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  logic             inflight;   // a read address was latched by the RAM last cycle
  logic             last_wr;    // most recent granted operation was a write
  logic             rsp_pop;
  logic             rsp_full;
  logic             rsp_empty;
  logic [CNT_W-1:0] rsp_count;
  logic [CNT_W:0]   credit_use;
  logic             rd_can;
  logic             wr_gnt;
  logic             rd_gnt;

  assign rsp_valid = rst_n && !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  // Entries committed after this cycle's pop, counting the read whose data lands this cycle.
  // Crediting the pop lets a steady read stream run at one read per cycle.
  assign credit_use = {1'b0, rsp_count} - {{CNT_W{1'b0}}, rsp_pop}
                    + {{CNT_W{1'b0}}, inflight};
  assign rd_can     = (credit_use < (CNT_W+1)'(RSP_DEPTH));

  // Write wins unless a read is also eligible and the previous grant was a write.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rst_n) begin
      if (wr_valid && rd_valid && rd_can) begin
        rd_gnt = last_wr;
        wr_gnt = !last_wr;
      end else if (wr_valid) begin
        wr_gnt = 1'b1;
      end else if (rd_valid && rd_can) begin
        rd_gnt = 1'b1;
      end
    end
  end

  // Drive the RAM port from the granted request; idle cycles park at zero.
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (wr_gnt) begin
      ram_en   = 1'b1;
      ram_addr = wr_addr;
      ram_data = wr_data;
    end else if (rd_gnt) begin
      ram_addr = rd_addr;
    end
  end

  assign wr_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  // Track the outstanding read and the fairness flag; only grants move last_wr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      last_wr  <= 1'b0;
    end else begin
      inflight <= rd_gnt;
      if (wr_gnt) begin
        last_wr <= 1'b1;
      end else if (rd_gnt) begin
        last_wr <= 1'b0;
      end
    end
  end

  // Credit accounting must keep the buffer from ever overflowing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(inflight && rsp_full && !rsp_pop));
    end
  end

  // RAM q is sampled in the cycle after the address latch, before any new latch lands.
  sp_ram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_data  (ram_q),
    .pop        (rsp_pop),
    .pop_data   (rsp_data),
    .full       (rsp_full),
    .empty      (rsp_empty),
    .count      (rsp_count)
  );

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl driving a 64x8 single_port_ram.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants and simple address arithmetic.
module tb_sp_ram_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_en;
  logic [DW-1:0] ram_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_en    (ram_en),
    .ram_q     (ram_q)
  );

  single_port_ram #(.data_width(DW), .addr_width(AW), .depth(64)) u_ram (
    .clk  (clk),
    .data (ram_data),
    .addr (ram_addr),
    .en   (ram_en),
    .q    (ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    int hs;

    // Reset with both requests asserted: everything must stay gated off.
    rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    // Write 5=0xA5 then read it back: response two cycles after handshake.
    tick(); rst_n = 1'b1; wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 8'hA5; rd_valid = 1'b0; #1;
    chk("w5_wr_ready", wr_ready, 1);
    chk("w5_ram_en", ram_en, 1);
    chk("w5_ram_addr", ram_addr, 5);
    chk("w5_ram_data", ram_data, 8'hA5);
    tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5; #1;
    chk("r5_rd_ready", rd_ready, 1);
    chk("r5_ram_en", ram_en, 0);
    chk("r5_ram_addr", ram_addr, 5);
    tick(); rd_valid = 1'b0; #1;
    chk("r5_n1_rsp_valid", rsp_valid, 0);
    chk("idle_ram_addr", ram_addr, 0);
    tick(); #1;
    chk("r5_n2_rsp_valid", rsp_valid, 1);
    chk("r5_n2_rsp_data", rsp_data, 8'hA5);
    rsp_ready = 1'b1;
    tick(); #1;
    chk("r5_drained", rsp_valid, 0);

    // Preload addresses 0..7 with addr^0x3C.
    for (int a = 0; a < 8; a++) begin
      tick(); wr_valid = 1'b1; wr_addr = 6'(a); wr_data = 8'(a) ^ 8'h3C; #1;
      chk("preload_wr_ready", wr_ready, 1);
    end
    tick(); wr_valid = 1'b0;

    // Back-to-back reads of 0..7: responses on 8 consecutive cycles, in order.
    for (int c = 0; c < 10; c++) begin
      tick(); rd_valid = (c < 8); rd_addr = 6'(c); #1;
      if (c < 8) chk("stream_rd_ready", rd_ready, 1);
      if (c >= 2) begin
        exp_d = 8'(c - 2) ^ 8'h3C;
        chk("stream_rsp_valid", rsp_valid, 1);
        chk("stream_rsp_data", rsp_data, exp_d);
      end else begin
        chk("stream_rsp_early", rsp_valid, 0);
      end
    end

    // Consumer stalled: exactly two reads (6, 7) accepted.
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 6'(c + 6); #1;
      chk("bp_rd_ready", rd_ready, (c < 2) ? 1 : 0);
      if (rd_ready) hs++;
    end
    chk("bp_handshakes", hs, 2);

    // Consumer resumes: buffered 0x3A,0x3B drain while reads of 0,1 resume.
    tick(); rsp_ready = 1'b1; rd_addr = 6'd0; #1;
    chk("res_d0_valid", rsp_valid, 1);
    chk("res_d0_data", rsp_data, 8'h3A);
    chk("res_d0_rd_ready", rd_ready, 1);
    tick(); rd_addr = 6'd1; #1;
    chk("res_d1_data", rsp_data, 8'h3B);
    chk("res_d1_rd_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0; #1;
    chk("res_d2_valid", rsp_valid, 1);
    chk("res_d2_data", rsp_data, 8'h3C);
    tick(); #1;
    chk("res_d3_data", rsp_data, 8'h3D);
    tick(); #1;
    chk("res_d4_empty", rsp_valid, 0);

    // Fresh reset, then both streams held: W,R,W,R.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); wr_valid = 1'b1; wr_addr = 6'd20; wr_data = 8'h55; rd_valid = 1'b1; rd_addr = 6'd1; #1;
      chk("alt_wr_ready", wr_ready, (c % 2 == 0) ? 1 : 0);
      chk("alt_rd_ready", rd_ready, (c % 2 == 1) ? 1 : 0);
    end
    tick(); wr_valid = 1'b0; rd_valid = 1'b0;
    tick();
    tick(); #1;
    chk("alt_drained", rsp_valid, 0);

    // Fill the buffer with two reads of addr 4, then both streams: writes only.
    tick(); rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 6'd4; #1;
    chk("fill0_rd_ready", rd_ready, 1);
    tick(); #1;
    chk("fill1_rd_ready", rd_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick(); wr_valid = 1'b1; wr_addr = 6'd21; wr_data = 8'h66; rd_valid = 1'b1; rd_addr = 6'd4; #1;
      chk("nocred_wr_ready", wr_ready, 1);
      chk("nocred_rd_ready", rd_ready, 0);
    end
    tick(); wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1; #1;
    chk("nocred_rsp0_valid", rsp_valid, 1);
    chk("nocred_rsp0_data", rsp_data, 8'h38);
    tick(); #1;
    chk("nocred_rsp1_data", rsp_data, 8'h38);
    tick(); #1;
    chk("nocred_empty", rsp_valid, 0);

    // Read-after-write on addr 3 returns the new value.
    tick(); wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 8'h11; #1;
    chk("raw_wr_ready", wr_ready, 1);
    tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd3; #1;
    chk("raw_rd_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0; #1;
    chk("raw_n1_valid", rsp_valid, 0);
    tick(); #1;
    chk("raw_valid", rsp_valid, 1);
    chk("raw_data", rsp_data, 8'h11);

    // Write in the capture cycle does not disturb the response; next read sees it.
    tick(); rd_valid = 1'b1; rd_addr = 6'd3; #1;
    chk("war_rd_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0; wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 8'h22; #1;
    chk("war_wr_ready", wr_ready, 1);
    tick(); wr_valid = 1'b0; #1;
    chk("war_valid", rsp_valid, 1);
    chk("war_old_data", rsp_data, 8'h11);
    tick(); rd_valid = 1'b1; rd_addr = 6'd3; #1;
    chk("war_reread_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0;
    tick(); #1;
    chk("war_new_data", rsp_data, 8'h22);

    // Reset right after a read: its response is discarded.
    tick(); rd_valid = 1'b1; rd_addr = 6'd5; #1;
    chk("rstmid_rd_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0; rst_n = 1'b0; #1;
    chk("rstmid_rsp_valid0", rsp_valid, 0);
    chk("rstmid_ram_en", ram_en, 0);
    tick(); rst_n = 1'b1; #1;
    chk("rstmid_rsp_valid1", rsp_valid, 0);
    tick(); #1;
    chk("rstmid_rsp_valid2", rsp_valid, 0);

    // RAM contents survive the reset.
    tick(); rd_valid = 1'b1; rd_addr = 6'd3; #1;
    chk("post_rd3_ready", rd_ready, 1);
    tick(); rd_addr = 6'd5; #1;
    chk("post_rd5_ready", rd_ready, 1);
    tick(); rd_valid = 1'b0; #1;
    chk("post_rsp3_valid", rsp_valid, 1);
    chk("post_rsp3_data", rsp_data, 8'h22);
    tick(); #1;
    chk("post_rsp5_data", rsp_data, 8'h39);
    tick(); #1;
    chk("post_empty", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
